rf_wb_arb: RTL and testbench
============================

# rf_wb_arb

Writeback arbiter and scoreboard that drives the single write port of the integer register file. It merges results from a single-cycle source (A, ALU path) and a long-latency source (B, load/mul-div path, buffered in a 2-entry FIFO) onto one registered write port. It also tracks per-register pending writes so issue logic can stall on RAW hazards. The register file has no write-to-read bypass, so the scoreboard holds a register busy until its write has actually landed.

## Interface
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive cycles a non-empty B FIFO may lose arbitration before B is forced
- `clk` in 1: clock
- `rst` in 1: reset; one clock; synchronous, active-high
- `iss_vld` in 1: an instruction writing `iss_rd` issues this cycle
- `iss_rd` in 5: destination register of the issuing instruction
- `a_vld` in 1: source A result valid
- `a_rdy` out 1: source A accepted this cycle
- `a_rd` in 5: source A destination
- `a_data` in DW: source A value
- `b_vld` in 1: source B result valid
- `b_rdy` out 1: source B FIFO can accept
- `b_rd` in 5: source B destination
- `b_data` in DW: source B value
- `wr_en` out 1: register-file write enable
- `rd_addr` out 5: register-file write address
- `rd_data` out DW: register-file write data
- `q1_addr` in 5: hazard query 1 address
- `q1_busy` out 1: `q1_addr` has a pending write
- `q2_addr` in 5: hazard query 2 address
- `q2_busy` out 1: `q2_addr` has a pending write

## Operation
- B FIFO: 2 entries holding {rd, data}.
  - Push when `b_vld && b_rdy`.
  - `b_rdy = !full && !rst`. No pass-through when full, even if a pop occurs the same cycle.
- Grant per cycle:
  - If `force_b` and the FIFO is non-empty, B is granted.
  - Otherwise A is granted if `a_vld`.
  - Otherwise B is granted if the FIFO is non-empty.
  - Otherwise nothing is granted.
- `a_rdy = !rst && !(force_b && fifo_nonempty)`. `a_rdy` does not depend on `a_vld`.
- Starvation counter:
  - Width `$clog2(STARVE_MAX+1)`.
  - Increments when the FIFO is non-empty and A is granted.
  - Clears on a B grant or when the FIFO is empty.
  - `force_b = (cnt == STARVE_MAX)`.
- Output register, updated on the grant cycle:
  - `wr_en <= granted && (winner.rd != 0)`
  - `rd_addr <= winner.rd`
  - `rd_data <= winner.data`
  - With no grant: `wr_en <= 0` and `rd_addr`/`rd_data` hold.
  - Writes to x0 are consumed (handshake completes) but never assert `wr_en`.
- Scoreboard `busy[31:1]`:
  - Set on `iss_vld && iss_rd != 0`.
  - Cleared at the clock edge that ends a cycle with `wr_en && rd_addr == r`.
  - If set and clear hit the same register in the same cycle, set wins.
  - x0 is never busy.
- Queries are combinational: `qN_busy = (qN_addr != 0) && busy[qN_addr]`.

## Timing
- Reset values: `wr_en=0`, `rd_addr=0`, `rd_data=0`, `busy=0`, FIFO empty, `cnt=0`, `a_rdy=0` and `b_rdy=0` while `rst` is high.
- Reset mid-operation discards FIFO contents and all busy bits. Nothing is written after reset.
- Latency, A: accept in cycle t → `wr_en` high in t+1 → rf updated and busy cleared at end of t+1 → `q_busy` low and rf read valid in t+2.
- Latency, B: push in cycle t → earliest grant t+1 → `wr_en` in t+2.
- Throughput: one write per cycle. At most one `wr_en` per cycle. No write is ever dropped.
- Write ordering: grant order. Two in-flight writes to the same register are an issue-logic error and are not checked here.

## Structure
- Package `rf_wb_pkg`: `REG_N=32`, `RA_W=5`, typedef `wb_req_t` {`logic [RA_W-1:0] rd`; `logic [DW-1:0] data`}.
- Sub-module `wb_fifo2`: 2-entry FIFO with registered `full`/`empty`, push/pop, and head output.
- Top level contains the arbiter, the starvation counter, the output register and the scoreboard.

## Test plan
- Reset, then `a_vld` with rd=5, data=0xDEADBEEF, held for one cycle → `a_rdy=1`; next cycle `wr_en=1`, `rd_addr=5`, `rd_data=0xDEADBEEF`; the following cycle `wr_en=0`.
- `iss_vld` with rd=7, then A writes rd=7 three cycles later; `q1_addr=7` throughout → `q1_busy=1` from the cycle after issue through the `wr_en` cycle; `0` from the next cycle. Querying x0 always gives `q*_busy=0`.
- `a_vld` held high continuously; push one B entry (rd=9) → B is granted on the cycle after 4 A wins, with `a_rdy=0` that cycle; `wr_en` with `rd_addr=9` appears one cycle later.
- Push 3 consecutive B entries while A is continuously valid → `b_rdy=0` after 2 pushes; the third beat is held; all three eventually written in push order.
- A write to rd=0 with data=0x1234 → `a_rdy=1`; `wr_en` stays 0; busy state unchanged.
- Same-cycle `iss_vld` rd=3 and a `wr_en` cycle with rd=3 → `busy[3]` remains 1. Then assert `rst` with the FIFO holding 2 entries → after reset `wr_en` never asserts and all `q*_busy=0`.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_wb_pkg;
    localparam int REG_N = 32;
    localparam int RA_W  = 5;
    // Data width carried by wb_req_t; the arbiter's DW parameter must match it.
    localparam int WB_DW = 32;

    typedef struct packed {
        logic [RA_W-1:0]  rd;
        logic [WB_DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO with registered full/empty flags and a head output.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: pushes while full are ignored; no pass-through on a same-cycle pop.
module wb_fifo2 #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;
    logic [1:0]   cnt;
    logic [1:0]   cnt_nxt;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rp];

    always_comb begin
        cnt_nxt = cnt;
        if (push_ok && !pop_ok) begin
            cnt_nxt = cnt + 2'd1;
        end else if (pop_ok && !push_ok) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            cnt   <= 2'd0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push_ok) begin
                wp <= ~wp;
            end
            if (pop_ok) begin
                rp <= ~rp;
            end
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == 2'd2);
            empty <= (cnt_nxt == 2'd0);
        end
    end

    // Storage needs no reset: the pointers and flags define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= din;
        end
    end
endmodule

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter (A direct, B via 2-entry FIFO) with RAW scoreboard.
// Latency: A accept -> wr_en next cycle; B push -> wr_en two cycles later at the earliest.
// Backpressure: b_rdy drops when the FIFO is full; a_rdy drops while B is being forced.
module rf_wb_arb
    import rf_wb_pkg::*;
#(
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_vld,
    input  logic [RA_W-1:0] iss_rd,
    input  logic            a_vld,
    output logic            a_rdy,
    input  logic [RA_W-1:0] a_rd,
    input  logic [DW-1:0]   a_data,
    input  logic            b_vld,
    output logic            b_rdy,
    input  logic [RA_W-1:0] b_rd,
    input  logic [DW-1:0]   b_data,
    output logic            wr_en,
    output logic [RA_W-1:0] rd_addr,
    output logic [DW-1:0]   rd_data,
    input  logic [RA_W-1:0] q1_addr,
    output logic            q1_busy,
    input  logic [RA_W-1:0] q2_addr,
    output logic            q2_busy
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0]    cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_ne;
    logic             force_b;
    logic             push_b;
    logic             grant_a;
    logic             grant_b;
    wb_req_t          a_req;
    wb_req_t          b_req;
    wb_req_t          b_head;
    wb_req_t          win;
    logic [REG_N-1:0] busy;
    logic [REG_N-1:0] busy_nxt;

    assign a_req.rd   = a_rd;
    assign a_req.data = a_data;
    assign b_req.rd   = b_rd;
    assign b_req.data = b_data;

    assign fifo_ne = !fifo_empty;
    assign force_b = (cnt == CW'(STARVE_MAX));
    assign b_rdy   = !fifo_full && !rst;
    assign a_rdy   = !rst && !(force_b && fifo_ne);
    assign push_b  = b_vld && b_rdy;

    // A and B grants are mutually exclusive: a forced B also drops a_rdy.
    assign grant_a = a_vld && a_rdy;
    assign grant_b = !rst && fifo_ne && (force_b || !a_vld);
    assign win     = grant_b ? b_head : a_req;

    wb_fifo2 #(
        .W($bits(wb_req_t))
    ) u_b_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .pop   (grant_b),
        .din   (b_req),
        .head  (b_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!fifo_ne || grant_b) begin
            cnt <= '0;
        end else if (grant_a) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else begin
            // x0 results complete their handshake but never reach the register file.
            wr_en <= (grant_a || grant_b) && (win.rd != '0);
            if (grant_a || grant_b) begin
                rd_addr <= win.rd;
                rd_data <= win.data;
            end
        end
    end

    // Issue is applied after the landing write so a same-cycle set wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[rd_addr] = 1'b0;
        end
        if (iss_vld) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign q1_busy = (q1_addr != '0) && busy[q1_addr];
    assign q2_busy = (q2_addr != '0) && busy[q2_addr];
endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: scenario tasks plus a write scoreboard
// fed by accepted A/B handshakes and drained by observed register-file writes.
module tb_rf_wb_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        iss_vld;
    logic [4:0]  iss_rd;
    logic        a_vld;
    logic        a_rdy;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_vld;
    logic        b_rdy;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  q1_addr;
    logic        q1_busy;
    logic [4:0]  q2_addr;
    logic        q2_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [36:0] a_q[$];
    logic [36:0] b_q[$];

    always #5 clk = ~clk;

    rf_wb_arb #(.DW(32), .STARVE_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .iss_vld (iss_vld),
        .iss_rd  (iss_rd),
        .a_vld   (a_vld),
        .a_rdy   (a_rdy),
        .a_rd    (a_rd),
        .a_data  (a_data),
        .b_vld   (b_vld),
        .b_rdy   (b_rdy),
        .b_rd    (b_rd),
        .b_data  (b_data),
        .wr_en   (wr_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .q1_addr (q1_addr),
        .q1_busy (q1_busy),
        .q2_addr (q2_addr),
        .q2_busy (q2_busy)
    );

    // Scoreboard: each source is in-order, so every write must match one head.
    initial begin
        logic [36:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (wr_en === 1'b1) begin
                got = {rd_addr, rd_data};
                n_tests++;
                if (a_q.size() > 0 && a_q[0] === got) begin
                    void'(a_q.pop_front());
                end else if (b_q.size() > 0 && b_q[0] === got) begin
                    void'(b_q.pop_front());
                end else begin
                    n_fail++;
                    $display("FAIL sb_write: got rd=%0d data=%h, not at head of A queue (%0d left) or B queue (%0d left)",
                             rd_addr, rd_data, a_q.size(), b_q.size());
                end
            end
            if (rst === 1'b1) begin
                a_q.delete();
                b_q.delete();
            end else begin
                if (a_vld && a_rdy === 1'b1 && a_rd != 5'd0) a_q.push_back({a_rd, a_data});
                if (b_vld && b_rdy === 1'b1) b_q.push_back({b_rd, b_data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        q1_addr = 5'd5;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        n_tests++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        n_tests++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        n_tests++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_a_rdy: got %b expected 0", a_rdy); end
        n_tests++; if (b_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_b_rdy: got %b expected 0", b_rdy); end
        n_tests++; if (q1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_q1_busy: got %b expected 0", q1_busy); end
        @(negedge clk); rst = 1'b0;
        #1;
        n_tests++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_a_rdy: got %b expected 1", a_rdy); end
        n_tests++; if (b_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_b_rdy: got %b expected 1", b_rdy); end
    endtask

    task automatic test_a_write();
        @(negedge clk); a_vld = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        n_tests++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL a_write_rdy: got %b expected 1", a_rdy); end
        @(negedge clk); a_vld = 1'b0;
        #1;
        n_tests++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL a_write_wr_en: got %b expected 1", wr_en); end
        n_tests++; if (rd_addr !== 5'd5) begin n_fail++; $display("FAIL a_write_addr: got %0d expected 5", rd_addr); end
        n_tests++; if (rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_write_data: got %h expected deadbeef", rd_data); end
        @(negedge clk);
        #1;
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL a_write_done: got %b expected 0", wr_en); end
        n_tests++; if (rd_addr !== 5'd5) begin n_fail++; $display("FAIL a_write_hold_addr: got %0d expected 5", rd_addr); end
    endtask

    task automatic test_scoreboard();
        q1_addr = 5'd7; q2_addr = 5'd0;
        @(negedge clk); iss_vld = 1'b1; iss_rd = 5'd7;
        #1;
        n_tests++; if (q1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_issue_cycle: got %b expected 0", q1_busy); end
        @(negedge clk); iss_vld = 1'b0;
        #1;
        n_tests++; if (q1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_t1: got %b expected 1", q1_busy); end
        @(negedge clk);
        #1;
        n_tests++; if (q1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_t2: got %b expected 1", q1_busy); end
        @(negedge clk); a_vld = 1'b1; a_rd = 5'd7; a_data = 32'h0000_0777;
        #1;
        n_tests++; if (q1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_t3: got %b expected 1", q1_busy); end
        @(negedge clk); a_vld = 1'b0;
        #1;
        n_tests++; if (wr_en !== 1'b1 || rd_addr !== 5'd7) begin n_fail++; $display("FAIL sb_write7: got wr_en=%b rd=%0d expected 1/7", wr_en, rd_addr); end
        n_tests++; if (q1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_wr_cycle: got %b expected 1", q1_busy); end
        n_tests++; if (q2_busy !== 1'b0) begin n_fail++; $display("FAIL sb_x0_query: got %b expected 0", q2_busy); end
        @(negedge clk); iss_vld = 1'b1; iss_rd = 5'd0;
        #1;
        n_tests++; if (q1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_cleared: got %b expected 0", q1_busy); end
        @(negedge clk); iss_vld = 1'b0;
        #1;
        n_tests++; if (q2_busy !== 1'b0) begin n_fail++; $display("FAIL sb_x0_issue: got %b expected 0", q2_busy); end
    endtask

    task automatic test_starvation();
        logic acc;
        @(negedge clk);
        a_vld = 1'b1; a_rd = 5'd10; a_data = 32'hA000_0000;
        b_vld = 1'b1; b_rd = 5'd9; b_data = 32'h9999_0009;
        #1;
        acc = a_rdy;
        n_tests++; if (b_rdy !== 1'b1) begin n_fail++; $display("FAIL starve_push: got b_rdy=%b expected 1", b_rdy); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); b_vld = 1'b0;
            if (acc) a_data = a_data + 32'd1;
            #1;
            acc = a_rdy;
            n_tests++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL starve_a_win%0d: got a_rdy=%b expected 1", i, a_rdy); end
        end
        @(negedge clk);
        if (acc) a_data = a_data + 32'd1;
        #1;
        n_tests++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL starve_force: got a_rdy=%b expected 0", a_rdy); end
        @(negedge clk); a_vld = 1'b0;
        #1;
        n_tests++; if (wr_en !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'h9999_0009) begin
            n_fail++; $display("FAIL starve_b_write: got wr_en=%b rd=%0d data=%h expected 1/9/99990009", wr_en, rd_addr, rd_data);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fifo_full();
        logic acc;
        logic got;
        @(negedge clk);
        a_vld = 1'b1; a_rd = 5'd10; a_data = 32'hB000_0000;
        b_vld = 1'b1; b_rd = 5'd11; b_data = 32'h0000_0B11;
        #1; acc = a_rdy;
        n_tests++; if (b_rdy !== 1'b1) begin n_fail++; $display("FAIL full_push1: got b_rdy=%b expected 1", b_rdy); end
        @(negedge clk); if (acc) a_data = a_data + 32'd1;
        b_rd = 5'd12; b_data = 32'h0000_0B12;
        #1; acc = a_rdy;
        n_tests++; if (b_rdy !== 1'b1) begin n_fail++; $display("FAIL full_push2: got b_rdy=%b expected 1", b_rdy); end
        @(negedge clk); if (acc) a_data = a_data + 32'd1;
        b_rd = 5'd13; b_data = 32'h0000_0B13;
        #1; acc = a_rdy;
        n_tests++; if (b_rdy !== 1'b0) begin n_fail++; $display("FAIL full_stall: got b_rdy=%b expected 0", b_rdy); end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); if (acc) a_data = a_data + 32'd1;
            #1; acc = a_rdy;
            if (b_rdy === 1'b1) got = 1'b1;
        end
        n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL full_third_push: got accepted=%b expected 1", got); end
        @(negedge clk); a_vld = 1'b0; b_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            if (a_q.size() == 0 && b_q.size() == 0) break;
        end
        n_tests++; if (a_q.size() != 0 || b_q.size() != 0) begin
            n_fail++; $display("FAIL full_drain: got %0d A / %0d B writes outstanding expected 0/0", a_q.size(), b_q.size());
        end
    endtask

    task automatic test_x0();
        q1_addr = 5'd4;
        @(negedge clk); iss_vld = 1'b1; iss_rd = 5'd4;
        @(negedge clk); iss_vld = 1'b0; a_vld = 1'b1; a_rd = 5'd0; a_data = 32'h1234;
        #1;
        n_tests++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL x0_rdy: got %b expected 1", a_rdy); end
        @(negedge clk); a_vld = 1'b0;
        #1;
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_no_write: got wr_en=%b expected 0", wr_en); end
        n_tests++; if (q1_busy !== 1'b1) begin n_fail++; $display("FAIL x0_busy_kept: got %b expected 1", q1_busy); end
        @(negedge clk); a_vld = 1'b1; a_rd = 5'd4; a_data = 32'h4444;
        @(negedge clk); a_vld = 1'b0;
        #1;
        n_tests++; if (wr_en !== 1'b1 || rd_addr !== 5'd4) begin n_fail++; $display("FAIL x0_write4: got wr_en=%b rd=%0d expected 1/4", wr_en, rd_addr); end
        @(negedge clk);
        #1;
        n_tests++; if (q1_busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy4_clear: got %b expected 0", q1_busy); end
    endtask

    task automatic test_set_clear_same();
        q1_addr = 5'd3;
        @(negedge clk); iss_vld = 1'b1; iss_rd = 5'd3;
        @(negedge clk); iss_vld = 1'b0; a_vld = 1'b1; a_rd = 5'd3; a_data = 32'h3333;
        @(negedge clk); a_vld = 1'b0; iss_vld = 1'b1; iss_rd = 5'd3;
        #1;
        n_tests++; if (wr_en !== 1'b1 || rd_addr !== 5'd3) begin n_fail++; $display("FAIL same_write3: got wr_en=%b rd=%0d expected 1/3", wr_en, rd_addr); end
        @(negedge clk); iss_vld = 1'b0; a_vld = 1'b1; a_rd = 5'd3; a_data = 32'h3334;
        #1;
        n_tests++; if (q1_busy !== 1'b1) begin n_fail++; $display("FAIL same_set_wins: got %b expected 1", q1_busy); end
        @(negedge clk); a_vld = 1'b0;
        @(negedge clk);
        #1;
        n_tests++; if (q1_busy !== 1'b0) begin n_fail++; $display("FAIL same_final_clear: got %b expected 0", q1_busy); end
    endtask

    task automatic test_reset_mid();
        logic saw;
        q1_addr = 5'd6; q2_addr = 5'd8;
        @(negedge clk);
        iss_vld = 1'b1; iss_rd = 5'd6;
        a_vld = 1'b1; a_rd = 5'd10; a_data = 32'hC000_0000;
        b_vld = 1'b1; b_rd = 5'd20; b_data = 32'h0000_0B20;
        @(negedge clk);
        iss_rd = 5'd8; a_data = 32'hC000_0001;
        b_rd = 5'd21; b_data = 32'h0000_0B21;
        @(negedge clk);
        iss_vld = 1'b0; a_vld = 1'b0; b_vld = 1'b0; rst = 1'b1;
        #1;
        n_tests++; if (q1_busy !== 1'b1 || q2_busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy: got %b/%b expected 1/1", q1_busy, q2_busy); end
        n_tests++; if (b_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_b_rdy: got %b expected 0", b_rdy); end
        @(negedge clk); rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1; if (wr_en !== 1'b0) saw = 1'b1;
            @(negedge clk);
        end
        #1;
        n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL mid_no_write: got write_seen=%b expected 0", saw); end
        n_tests++; if (q1_busy !== 1'b0 || q2_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_clear: got %b/%b expected 0/0", q1_busy, q2_busy); end
    endtask

    initial begin
        rst = 1'b1; iss_vld = 1'b0; iss_rd = 5'd0;
        a_vld = 1'b0; a_rd = 5'd0; a_data = 32'd0;
        b_vld = 1'b0; b_rd = 5'd0; b_data = 32'd0;
        q1_addr = 5'd0; q2_addr = 5'd0;
        test_reset();
        test_a_write();
        test_scoreboard();
        test_starvation();
        test_fifo_full();
        test_x0();
        test_set_clear_same();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
